// File: rtl/uop_pkg.sv
// Micro-op encoding shared by decode, the dispatch scheduler and the execution units.
package uop_pkg;

  parameter int INSTR_Q_DEPTH = 32;
  parameter int INSTR_Q_WIDTH = 5;

  typedef enum logic [5:0] {
    UOP_NOP,
    UOP_ADD,
    UOP_SUB,
    UOP_AND,
    UOP_OR,
    UOP_XOR,
    UOP_SHL,
    UOP_SHR,
    UOP_MOV,
    UOP_CMP,
    UOP_LOAD,
    UOP_STORE,
    UOP_FMOV,
    UOP_FNEG,
    UOP_FADD,
    UOP_FMUL,
    UOP_FSUB,
    UOP_BCOND,
    UOP_BL,
    UOP_CHECK_RET,
    UOP_HLT
  } uopcode_t;

  typedef struct packed {
    uopcode_t    uopcode;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [15:0] imm;
  } uop_insn;

endpackage

// File: rtl/uop_dispatch_sched_if.sv
// Decode-side and execution-unit-side handshake bundle of uop_dispatch_sched.
// master = surrounding pipeline (decode + units), slave = scheduler.
interface uop_dispatch_sched_if #(
  parameter int PTR_W = uop_pkg::INSTR_Q_WIDTH
);
  logic             uop_valid_in;
  uop_pkg::uop_insn uop_in;
  logic             uop_ready_out;
  logic             flush_in;
  uop_pkg::uop_insn disp_uop_out;
  logic             alu_valid_out;
  logic             alu_ready_in;
  logic             fpu_valid_out;
  logic             fpu_ready_in;
  logic             lsu_valid_out;
  logic             lsu_ready_in;
  logic             br_valid_out;
  logic             br_ready_in;
  logic [PTR_W:0]   occupancy_out;
  logic             halted_out;

  modport master (
    output uop_valid_in, uop_in, flush_in,
    output alu_ready_in, fpu_ready_in, lsu_ready_in, br_ready_in,
    input  uop_ready_out, disp_uop_out,
    input  alu_valid_out, fpu_valid_out, lsu_valid_out, br_valid_out,
    input  occupancy_out, halted_out
  );

  modport slave (
    input  uop_valid_in, uop_in, flush_in,
    input  alu_ready_in, fpu_ready_in, lsu_ready_in, br_ready_in,
    output uop_ready_out, disp_uop_out,
    output alu_valid_out, fpu_valid_out, lsu_valid_out, br_valid_out,
    output occupancy_out, halted_out
  );
endinterface

// File: rtl/uop_dispatch_sched.sv
// In-order uop FIFO that issues its head to ALU/FPU/LSU/branch and halts on UOP_HLT.
// Optional same-cycle issue from an empty queue: define UOP_SCHED_BYPASS_EN.
module uop_dispatch_sched #(
  parameter int DEPTH = uop_pkg::INSTR_Q_DEPTH,
  parameter int PTR_W = uop_pkg::INSTR_Q_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  uop_dispatch_sched_if.slave  bus
);

  typedef enum logic {ST_RUN, ST_HALTED} state_e;
  typedef enum logic [2:0] {UNIT_ALU, UNIT_FPU, UNIT_LSU, UNIT_BR, UNIT_NONE} unit_e;

  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  function automatic unit_e classify(input uop_pkg::uopcode_t op);
    unit_e u;
    case (op)
      uop_pkg::UOP_LOAD, uop_pkg::UOP_STORE:                           u = UNIT_LSU;
      uop_pkg::UOP_FMOV, uop_pkg::UOP_FNEG, uop_pkg::UOP_FADD,
      uop_pkg::UOP_FMUL, uop_pkg::UOP_FSUB:                            u = UNIT_FPU;
      uop_pkg::UOP_BCOND, uop_pkg::UOP_BL, uop_pkg::UOP_CHECK_RET:     u = UNIT_BR;
      uop_pkg::UOP_HLT:                                                u = UNIT_NONE;
      default:                                                         u = UNIT_ALU;
    endcase
    return u;
  endfunction

  state_e           state, state_nxt;
  uop_pkg::uop_insn mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;

  uop_pkg::uop_insn head, disp_uop;
  unit_e            head_unit, sel_unit;
  logic             head_vld, can_issue, ready_c, enq, hlt_pop;
  logic             sel_ready, byp_take, pop, wr_en;

  assign head      = mem[rd_ptr];
  assign head_vld  = (count != '0);
  assign head_unit = classify(head.uopcode);
  assign can_issue = (state == ST_RUN) && !bus.flush_in;
  assign ready_c   = (count < DEPTH_C) && can_issue;
  assign enq       = bus.uop_valid_in && ready_c;
  assign hlt_pop   = can_issue && head_vld && (head_unit == UNIT_NONE);

  // Unit selection: the queue head has priority; an empty queue may forward uop_in.
  always_comb begin
    sel_unit = UNIT_NONE;
    disp_uop = head;
    byp_take = 1'b0;
    if (can_issue && head_vld) begin
      sel_unit = head_unit;
    end
`ifdef UOP_SCHED_BYPASS_EN
    else if (enq && classify(bus.uop_in.uopcode) != UNIT_NONE) begin
      sel_unit = classify(bus.uop_in.uopcode);
      disp_uop = bus.uop_in;
      byp_take = 1'b1;
    end
`endif
    case (sel_unit)
      UNIT_ALU: sel_ready = bus.alu_ready_in;
      UNIT_FPU: sel_ready = bus.fpu_ready_in;
      UNIT_LSU: sel_ready = bus.lsu_ready_in;
      UNIT_BR:  sel_ready = bus.br_ready_in;
      default:  sel_ready = 1'b0;
    endcase
  end

  // A bypassed uop taken by its unit never enters the queue.
  assign pop   = (head_vld && !byp_take && (sel_unit != UNIT_NONE) && sel_ready) || hlt_pop;
  assign wr_en = enq && !(byp_take && sel_ready);

  always_comb begin
    case ({wr_en, pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN && hlt_pop) state_nxt = ST_HALTED;
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) state <= ST_RUN;
    else           state <= state_nxt;
  end

  // Flush wins over enqueue and dispatch; HALTED is kept across a flush.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= bus.uop_in;
  end

  assign bus.uop_ready_out = ready_c;
  assign bus.disp_uop_out  = disp_uop;
  assign bus.alu_valid_out = (sel_unit == UNIT_ALU);
  assign bus.fpu_valid_out = (sel_unit == UNIT_FPU);
  assign bus.lsu_valid_out = (sel_unit == UNIT_LSU);
  assign bus.br_valid_out  = (sel_unit == UNIT_BR);
  assign bus.occupancy_out = count;
  assign bus.halted_out    = (state == ST_HALTED);

endmodule
